// File: rtl/aes_gf_pkg.sv
// rtl/aes_gf_pkg.sv - GF(2^8) helpers, mode codes and FSM states for the MixColumns engine
package aes_gf_pkg;

  localparam logic [7:0] GF_POLY  = 8'h1B;
  localparam logic       MODE_FWD = 1'b0;
  localparam logic       MODE_INV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// rtl/mix_columns_engine_if.sv - block in/out handshake bundle for the MixColumns engine
interface mix_columns_engine_if #(
  parameter int NUM_COLS = 4
);

  localparam int DW = 32 * NUM_COLS;

  logic          in_valid;
  logic          in_ready;
  logic          mode;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic          busy;

  modport master (
    output in_valid, mode, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, mode, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );

endinterface

// File: rtl/mix_column_word.sv
// rtl/mix_column_word.sv - combinational MixColumns/InvMixColumns of one 32-bit column
module mix_column_word
  import aes_gf_pkg::*;
(
  input  logic        i_mode,
  input  logic [31:0] i_col_in,
  output logic [31:0] o_col_out
);

  logic [7:0] w_a  [4];
  logic [7:0] w_x2 [4];
  logic [7:0] w_x4 [4];
  logic [7:0] w_x8 [4];
  logic [7:0] w_r  [4];

  for (genvar i = 0; i < 4; i++) begin : g_byte
    localparam int J1 = (i + 1) % 4;
    localparam int J2 = (i + 2) % 4;
    localparam int J3 = (i + 3) % 4;

    assign w_a[i]  = i_col_in[31-8*i -: 8];
    assign w_x2[i] = xtime(w_a[i]);
    assign w_x4[i] = xtime(w_x2[i]);
    assign w_x8[i] = xtime(w_x4[i]);

    // inverse coefficients: 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1
    assign w_r[i] = (i_mode == MODE_FWD)
      ? (w_x2[i] ^ (w_x2[J1] ^ w_a[J1]) ^ w_a[J2] ^ w_a[J3])
      : ((w_x8[i] ^ w_x4[i] ^ w_x2[i]) ^
         (w_x8[J1] ^ w_x2[J1] ^ w_a[J1]) ^
         (w_x8[J2] ^ w_x4[J2] ^ w_a[J2]) ^
         (w_x8[J3] ^ w_a[J3]));
  end

  assign o_col_out = {w_r[0], w_r[1], w_r[2], w_r[3]};

endmodule

// File: rtl/mix_columns_engine.sv
// rtl/mix_columns_engine.sv - AES MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per beat
module mix_columns_engine
  import aes_gf_pkg::*;
#(
  parameter int NUM_COLS       = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  mix_columns_engine_if.slave bus
);

  localparam int DW    = 32 * NUM_COLS;
  localparam int BEATS = NUM_COLS / COLS_PER_CYCLE;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (NUM_COLS % COLS_PER_CYCLE != 0) begin : g_cfg_check
    $error("mix_columns_engine: NUM_COLS must be a multiple of COLS_PER_CYCLE");
  end

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_work;
  logic             r_mode;
  logic [DW-1:0]    w_work_next;
  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_col_in  [COLS_PER_CYCLE];
  logic [31:0]      w_col_out [COLS_PER_CYCLE];

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == CNT_W'(BEATS - 1));

  // Each lane picks its column for the current beat with an AND-OR chain
  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
      logic [31:0] w_cand;
      logic [31:0] w_acc;
      assign w_cand = (r_cnt == CNT_W'(b)) ? r_work[DW-1-32*(b*COLS_PER_CYCLE+i) -: 32] : 32'h0;
      if (b == 0) begin : g_first
        assign w_acc = w_cand;
      end else begin : g_rest
        assign w_acc = g_beat[b-1].w_acc | w_cand;
      end
    end

    assign w_col_in[i] = g_beat[BEATS-1].w_acc;

    mix_column_word u_word (
      .i_mode    (r_mode),
      .i_col_in  (w_col_in[i]),
      .o_col_out (w_col_out[i])
    );
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    assign w_work_next[DW-1-32*c -: 32] = (r_cnt == CNT_W'(c / COLS_PER_CYCLE))
      ? w_col_out[c % COLS_PER_CYCLE]
      : r_work[DW-1-32*c -: 32];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_next = BUSY;
      BUSY:    if (w_last)        w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_work <= '0;
      r_mode <= MODE_FWD;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_work <= bus.data_in;
      r_mode <= bus.mode;
    end else if (r_state == BUSY) begin
      r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
      r_work <= w_work_next;
    end
  end

  assign bus.in_ready  = rst && (r_state == IDLE);
  assign bus.busy      = (r_state == BUSY);
  assign bus.out_valid = (r_state == DONE);
  assign bus.data_out  = r_work;

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb/tb_mix_columns_engine.sv - directed self-checking bench for mix_columns_engine
module tb_mix_columns_engine;

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] V2_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mix_columns_engine_if #(.NUM_COLS(4)) if0 ();
  mix_columns_engine_if #(.NUM_COLS(4)) if1 ();
  mix_columns_engine_if #(.NUM_COLS(4)) if2 ();

  mix_columns_engine #(.NUM_COLS(4), .COLS_PER_CYCLE(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mix_columns_engine #(.NUM_COLS(4), .COLS_PER_CYCLE(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  mix_columns_engine #(.NUM_COLS(4), .COLS_PER_CYCLE(4)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    if0.in_valid = 1'b0; if0.mode = 1'b0; if0.data_in = '0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.mode = 1'b0; if1.data_in = '0; if1.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.mode = 1'b0; if2.data_in = '0; if2.out_ready = 1'b0;
  endtask

  task automatic start0(input logic m, input logic [127:0] d);
    if0.mode = m; if0.data_in = d; if0.in_valid = 1'b1;
    tick;
    if0.in_valid = 1'b0;
  endtask

  task automatic wait_out0(output int n);
    n = 0;
    while (if0.out_valid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
  endtask

  task automatic drain0;
    if0.out_ready = 1'b1;
    tick;
    if0.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs;
    rst = 1'b0;
    tick;
    tick;
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", if0.out_valid); end
    checks++; if (if0.data_out !== 128'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", if0.data_out); end
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", if0.busy); end
    checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %0b expected 0", if0.in_ready); end
    rst = 1'b1;
    #1;
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high: got %0b expected 1", if0.in_ready); end
    checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_cpc4: got %0b expected 1", if2.in_ready); end
  endtask

  task automatic test_fwd;
    int n;
    start0(1'b0, V1_IN);
    checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL fwd_busy: got %0b expected 1", if0.busy); end
    checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL fwd_in_ready: got %0b expected 0", if0.in_ready); end
    wait_out0(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL fwd_latency: got %0d expected 4", n); end
    checks++; if (if0.data_out !== V1_OUT) begin errors++; $display("FAIL fwd_data: got %h expected %h", if0.data_out, V1_OUT); end
    drain0;
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL fwd_drain: got %0b expected 0", if0.out_valid); end
  endtask

  task automatic test_inv;
    int n;
    start0(1'b1, V2_IN);
    wait_out0(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL inv_latency: got %0d expected 4", n); end
    checks++; if (if0.data_out !== V2_OUT) begin errors++; $display("FAIL inv_data: got %h expected %h", if0.data_out, V2_OUT); end
    drain0;
  endtask

  task automatic test_backpressure;
    int n;
    start0(1'b0, V1_IN);
    wait_out0(n);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        if0.in_valid = 1'b1; if0.mode = 1'b1; if0.data_in = V2_IN;
      end
      tick;
      checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %0b expected 1", k, if0.out_valid); end
      checks++; if (if0.data_out !== V1_OUT) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", k, if0.data_out, V1_OUT); end
      checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0b expected 0", k, if0.in_ready); end
    end
    if0.out_ready = 1'b1;
    tick;
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %0b expected 0", if0.out_valid); end
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL bp_no_reaccept: got %0b expected 0", if0.busy); end
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after: got %0b expected 1", if0.in_ready); end
    idle_inputs;
    tick;
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy: got %0b expected 0", if0.busy); end
  endtask

  task automatic test_reset_mid;
    int n;
    start0(1'b0, V1_IN);
    tick;
    tick;
    rst = 1'b0;
    tick;
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %0b expected 0", if0.out_valid); end
    checks++; if (if0.data_out !== 128'h0) begin errors++; $display("FAIL rmid_data_out: got %h expected 0", if0.data_out); end
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b expected 0", if0.busy); end
    rst = 1'b1;
    #1;
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %0b expected 1", if0.in_ready); end
    start0(1'b1, V2_IN);
    wait_out0(n);
    checks++; if (if0.data_out !== V2_OUT) begin errors++; $display("FAIL rmid_new_data: got %h expected %h", if0.data_out, V2_OUT); end
    drain0;
  endtask

  task automatic test_sweep;
    int lat0 = 0;
    int lat1 = 0;
    int lat2 = 0;
    if0.mode = 1'b0; if0.data_in = V1_IN; if0.in_valid = 1'b1;
    if1.mode = 1'b0; if1.data_in = V1_IN; if1.in_valid = 1'b1;
    if2.mode = 1'b0; if2.data_in = V1_IN; if2.in_valid = 1'b1;
    tick;
    idle_inputs;
    for (int n = 1; n <= 8; n++) begin
      tick;
      if (lat0 == 0 && if0.out_valid === 1'b1) lat0 = n;
      if (lat1 == 0 && if1.out_valid === 1'b1) lat1 = n;
      if (lat2 == 0 && if2.out_valid === 1'b1) lat2 = n;
    end
    checks++; if (lat0 !== 4) begin errors++; $display("FAIL sweep_lat_cpc1: got %0d expected 4", lat0); end
    checks++; if (lat1 !== 2) begin errors++; $display("FAIL sweep_lat_cpc2: got %0d expected 2", lat1); end
    checks++; if (lat2 !== 1) begin errors++; $display("FAIL sweep_lat_cpc4: got %0d expected 1", lat2); end
    checks++; if (if0.data_out !== V1_OUT) begin errors++; $display("FAIL sweep_data_cpc1: got %h expected %h", if0.data_out, V1_OUT); end
    checks++; if (if1.data_out !== V1_OUT) begin errors++; $display("FAIL sweep_data_cpc2: got %h expected %h", if1.data_out, V1_OUT); end
    checks++; if (if2.data_out !== V1_OUT) begin errors++; $display("FAIL sweep_data_cpc4: got %h expected %h", if2.data_out, V1_OUT); end
    if0.out_ready = 1'b1; if1.out_ready = 1'b1; if2.out_ready = 1'b1;
    tick;
    idle_inputs;
  endtask

  task automatic test_mode_change;
    int n;
    start0(1'b0, V1_IN);
    if0.mode = 1'b1; if0.data_in = V2_IN;
    tick;
    if0.mode = 1'b0; if0.data_in = '1;
    tick;
    if0.mode = 1'b1;
    wait_out0(n);
    checks++; if (if0.data_out !== V1_OUT) begin errors++; $display("FAIL modechg_data: got %h expected %h", if0.data_out, V1_OUT); end
    drain0;
    idle_inputs;
  endtask

  task automatic test_back_to_back;
    int t[3] = '{-100, -100, -100};
    int hits = 0;
    if0.mode = 1'b0; if0.data_in = V1_IN; if0.in_valid = 1'b1; if0.out_ready = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      tick;
      if (if0.out_valid === 1'b1 && hits < 3) begin
        t[hits] = n;
        hits++;
        checks++; if (if0.data_out !== V1_OUT) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", hits, if0.data_out, V1_OUT); end
      end
    end
    checks++; if (t[1] - t[0] !== 6) begin errors++; $display("FAIL b2b_interval0: got %0d expected 6", t[1] - t[0]); end
    checks++; if (t[2] - t[1] !== 6) begin errors++; $display("FAIL b2b_interval1: got %0d expected 6", t[2] - t[1]); end
    if0.in_valid = 1'b0;
    for (int n = 0; n < 6; n++) tick;
    idle_inputs;
  endtask

  initial begin
    test_reset;
    test_fwd;
    test_inv;
    test_backpressure;
    test_reset_mid;
    test_sweep;
    test_mode_change;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
